traffic_light_ctrl: RTL and testbench

Parametrised two-direction traffic-light controller. Phase durations are set by parameters and counted in ticks from an external 1-cycle tick strobe, not in raw clocks. Adds three things to the fixed-timing intersection controller: an all-red clearance phase, pedestrian-request green shortening, and a flashing-yellow maintenance mode. Sits at the top of the intersection design, with light outputs driving the lamp drivers and the countdown driving the display.

---
 rtl/traffic_light_ctrl.sv | 148 ++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-direction intersection controller with all-red
// clearance, pedestrian green shortening and flashing-yellow maintenance
// mode. Phase timing is counted in ticks of an external 1-cycle strobe.
// Optional feature macro: PED_REQ_EN (pedestrian request shortening).
module traffic_light_ctrl #(
  parameter int GREEN_A_T   = 25,
  parameter int GREEN_B_T   = 25,
  parameter int YELLOW_T    = 5,
  parameter int ALLRED_T    = 2,
  parameter int MIN_GREEN_T = 5,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ped_req,
  input  logic             flash_mode,
  output logic [2:0]       light_a,
  output logic [2:0]       light_b,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       state_o
);

  localparam logic [2:0] ST_ALLRED = 3'd0;
  localparam logic [2:0] ST_AG     = 3'd1;
  localparam logic [2:0] ST_AY     = 3'd2;
  localparam logic [2:0] ST_BG     = 3'd3;
  localparam logic [2:0] ST_BY     = 3'd4;
  localparam logic [2:0] ST_FLASH  = 3'd5;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [CNT_W-1:0] L_GA  = CNT_W'(GREEN_A_T - 1);
  localparam logic [CNT_W-1:0] L_GB  = CNT_W'(GREEN_B_T - 1);
  localparam logic [CNT_W-1:0] L_Y   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] L_AR  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] L_MIN = CNT_W'(MIN_GREEN_T - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_flash_on;
  logic             r_ped_pend;
  logic [2:0]       r_light_a;
  logic [2:0]       r_light_b;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_flash_nxt;
  logic             w_pend_nxt;
  logic             w_pend_acc;
  logic             w_ped_eff;
  logic [2:0]       w_la_nxt;
  logic [2:0]       w_lb_nxt;

`ifdef PED_REQ_EN
  // Request seen this cycle counts immediately, so a request coinciding with a tick is honoured.
  assign w_ped_eff  = r_ped_pend | ped_req;
  assign w_pend_acc = r_ped_pend | ped_req;
`else
  logic w_unused_ped_req;
  assign w_unused_ped_req = ped_req;
  assign w_ped_eff  = 1'b0;
  assign w_pend_acc = 1'b0;
`endif

  // Next-state, countdown, flash phase and pending-request computation.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_flash_nxt = r_flash_on;
    w_pend_nxt  = w_pend_acc;
    if (flash_mode) begin
      w_state_nxt = ST_FLASH;
      w_pend_nxt  = 1'b0;
      if (r_state != ST_FLASH) begin
        w_count_nxt = '0;
        w_flash_nxt = 1'b1;
      end else if (tick) begin
        w_flash_nxt = ~r_flash_on;
      end
    end else if (r_state == ST_FLASH) begin
      w_state_nxt = ST_ALLRED;
      w_count_nxt = L_AR;
      w_flash_nxt = 1'b0;
      w_pend_nxt  = 1'b0;
    end else if (tick) begin
      if (r_count == '0) begin
        case (r_state)
          ST_ALLRED: begin w_state_nxt = ST_AG; w_count_nxt = L_GA; end
          ST_AG:     begin w_state_nxt = ST_AY; w_count_nxt = L_Y;  w_pend_nxt = 1'b0; end
          ST_AY:     begin w_state_nxt = ST_BG; w_count_nxt = L_GB; end
          ST_BG:     begin w_state_nxt = ST_BY; w_count_nxt = L_Y;  w_pend_nxt = 1'b0; end
          ST_BY:     begin w_state_nxt = ST_AG; w_count_nxt = L_GA; end
          default:   begin w_state_nxt = ST_ALLRED; w_count_nxt = L_AR; end
        endcase
      end else if ((r_state == ST_AG || r_state == ST_BG) && w_ped_eff && (r_count > L_MIN)) begin
        w_count_nxt = L_MIN;
      end else begin
        w_count_nxt = r_count - 1'b1;
      end
    end
  end

  // Lamp pattern decoded from the next state so lamps register alongside it.
  always_comb begin
    w_la_nxt = LAMP_R;
    w_lb_nxt = LAMP_R;
    case (w_state_nxt)
      ST_AG: w_la_nxt = LAMP_G;
      ST_AY: w_la_nxt = LAMP_Y;
      ST_BG: w_lb_nxt = LAMP_G;
      ST_BY: w_lb_nxt = LAMP_Y;
      ST_FLASH: begin
        w_la_nxt = w_flash_nxt ? LAMP_Y : LAMP_OFF;
        w_lb_nxt = w_flash_nxt ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

  // State, countdown and lamp registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ALLRED;
      r_count    <= L_AR;
      r_flash_on <= 1'b0;
      r_ped_pend <= 1'b0;
      r_light_a  <= LAMP_R;
      r_light_b  <= LAMP_R;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_flash_on <= w_flash_nxt;
      r_ped_pend <= w_pend_nxt;
      r_light_a  <= w_la_nxt;
      r_light_b  <= w_lb_nxt;
    end
  end

  assign light_a = r_light_a;
  assign light_b = r_light_b;
  assign count   = r_count;
  assign state_o = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed testbench for traffic_light_ctrl with default parameters.
// Expected values depend on whether PED_REQ_EN is defined.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       ped_req;
  logic       flash_mode;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic [5:0] count;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;

`ifdef PED_REQ_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  traffic_light_ctrl #(
    .GREEN_A_T(25), .GREEN_B_T(25), .YELLOW_T(5),
    .ALLRED_T(2), .MIN_GREEN_T(5), .CNT_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ped_req(ped_req),
    .flash_mode(flash_mode), .light_a(light_a), .light_b(light_b),
    .count(count), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int cnt, input int la, input int lb);
    chk({tag, ".state"}, int'(state_o), st);
    chk({tag, ".count"}, int'(count), cnt);
    chk({tag, ".light_a"}, int'(light_a), la);
    chk({tag, ".light_b"}, int'(light_b), lb);
  endtask

  // One clock with the given tick/ped_req, sampled 1ns after the edge.
  task automatic step(input logic t, input logic p);
    tick = t;
    ped_req = p;
    @(posedge clk);
    #1;
    tick = 1'b0;
    ped_req = 1'b0;
  endtask

  // Tick until the DUT shows the requested state/count, bounded.
  task automatic advance_to(input string tag, input logic [2:0] st, input logic [5:0] cnt);
    int guard = 0;
    while (!(state_o === st && count === cnt) && guard < 300) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk({tag, ".reach_state"}, int'(state_o), int'(st));
    chk({tag, ".reach_count"}, int'(count), int'(cnt));
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    tick = 1'b0;
    ped_req = 1'b0;
    flash_mode = 1'b0;
    #22;
    chk_all("reset", 0, 1, 3'b100, 3'b100);
    #1 rst_n = 1'b1;

    // Test 1: ALLRED clearance then AG
    step(1'b0, 1'b0);
    chk_all("t1_notick", 0, 1, 3'b100, 3'b100);
    step(1'b1, 1'b0);
    chk_all("t1_tick1", 0, 0, 3'b100, 3'b100);
    step(1'b1, 1'b0);
    chk_all("t1_ag", 1, 24, 3'b001, 3'b100);

    // Test 2: full cycle of 60 ticks
    for (int i = 1; i <= 60; i++) begin
      step(1'b1, 1'b0);
      chk("t2_one_red", int'(light_a[2] | light_b[2]), 1);
      if (i == 24) chk_all("t2_ag_last", 1, 0, 3'b001, 3'b100);
      if (i == 25) chk_all("t2_ay", 2, 4, 3'b010, 3'b100);
      if (i == 30) chk_all("t2_bg", 3, 24, 3'b100, 3'b001);
      if (i == 55) chk_all("t2_by", 4, 4, 3'b100, 3'b010);
      if (i == 60) chk_all("t2_ag_again", 1, 24, 3'b001, 3'b100);
    end

    // Test 3: request pulse in AG at count 20
    repeat (4) step(1'b1, 1'b0);
    chk("t3_cnt20", int'(count), 20);
    step(1'b0, 1'b1);
    chk("t3_pulse_hold", int'(count), 20);
    step(1'b1, 1'b0);
    chk("t3_short", int'(count), PED ? 4 : 19);
    k = PED ? 5 : 20;
    repeat (k - 1) step(1'b1, 1'b0);
    chk_all("t3_ag_end", 1, 0, 3'b001, 3'b100);
    step(1'b1, 1'b0);
    chk_all("t3_ay", 2, 4, 3'b010, 3'b100);
    step(1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    chk_all("t3_bg", 3, 24, 3'b100, 3'b001);
    step(1'b1, 1'b0);
    chk("t3_bg_short", int'(count), PED ? 4 : 23);

    // Test 4: request with tick on same edge; no lengthening near end
    advance_to("t4a", 3'd3, 6'd10);
    step(1'b1, 1'b1);
    chk("t4_same_edge", int'(count), PED ? 4 : 9);
    advance_to("t4b", 3'd1, 6'd3);
    step(1'b1, 1'b1);
    chk_all("t4_no_lengthen", 1, 2, 3'b001, 3'b100);

    // Test 5: flash mode entered mid-BG, with priority over a tick
    advance_to("t5", 3'd3, 6'd15);
    flash_mode = 1'b1;
    step(1'b1, 1'b1);
    chk_all("t5_flash", 5, 0, 3'b010, 3'b010);
    step(1'b1, 1'b0);
    chk_all("t5_off", 5, 0, 3'b000, 3'b000);
    step(1'b1, 1'b0);
    chk_all("t5_on", 5, 0, 3'b010, 3'b010);
    step(1'b0, 1'b0);
    chk_all("t5_hold", 5, 0, 3'b010, 3'b010);
    flash_mode = 1'b0;
    step(1'b0, 1'b0);
    chk_all("t5_allred", 0, 1, 3'b100, 3'b100);
    step(1'b1, 1'b0);
    chk_all("t5_allred0", 0, 0, 3'b100, 3'b100);
    step(1'b1, 1'b0);
    chk_all("t5_ag", 1, 24, 3'b001, 3'b100);

    // Tick held for three clocks counts three times
    tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 tick = 1'b0;
    chk("held_tick", int'(count), 21);

    // Test 6: asynchronous reset between edges mid-AY
    advance_to("t6", 3'd2, 6'd2);
    #3 rst_n = 1'b0;
    #1;
    chk_all("t6_async_rst", 0, 1, 3'b100, 3'b100);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("t6_after_rst", 0, 1, 3'b100, 3'b100);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk_all("t6_ag", 1, 24, 3'b001, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
